// File: rtl/fp_mul_pipe_arb_ctrl.sv
// Purpose : round-robin arbiter + valid/tag token pipeline steering one shared pipelined FP multiplier.
// Latency : LAT cycles from grant to out_valid; one result per cycle when out_ready is held high.
// Backpr. : out_valid & ~out_ready freezes the whole pipe (mul_en=0) and blocks new grants.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (dominates flush and all inputs)
//   req / gnt         per-requester operand valid / combinational one-hot grant
//   op_sel, op_valid  operand-mux select (0 when idle) and "token enters stage 0 this edge"
//   mul_en            common stage enable for every datapath register stage
//   flush             kills every in-flight token; the round-robin pointer is untouched
//   out_valid/out_tag/out_ready  result handshake and owning requester index
//   busy              any token in flight
// Optional: define FP_MUL_ARB_PERF_EN to add saturating perf_issue/perf_stall/perf_done counters.

module fp_mul_pipe_arb_ctrl #(
    parameter int NREQ  = 4,
    parameter int LAT   = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [TAG_W-1:0] op_sel,
    output logic             op_valid,
    output logic             mul_en,
    input  logic             flush,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    input  logic             out_ready,
    output logic             busy
`ifdef FP_MUL_ARB_PERF_EN
    ,
    output logic [31:0]      perf_issue,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_done
`endif
);

    logic [LAT-1:0]   vld_q;
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] ptr_q;
    logic             found_hi;
    logic             found_lo;
    logic [NREQ-1:0]  gnt_hi;
    logic [NREQ-1:0]  gnt_lo;
    logic [TAG_W-1:0] sel_hi;
    logic [TAG_W-1:0] sel_lo;

    assign out_valid = vld_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
    assign busy      = |vld_q;
    // The only way the pipe can stall is a result that is not being taken.
    assign mul_en    = ~(vld_q[LAT-1] & ~out_ready);

    // Round-robin search split in two halves: the first request at or above the
    // pointer wins; only if there is none does the lowest request below it win.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        gnt_hi   = '0;
        gnt_lo   = '0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !found_hi && (TAG_W'(i) >= ptr_q)) begin
                found_hi  = 1'b1;
                gnt_hi[i] = 1'b1;
                sel_hi    = TAG_W'(i);
            end
            if (req[i] && !found_lo) begin
                found_lo  = 1'b1;
                gnt_lo[i] = 1'b1;
                sel_lo    = TAG_W'(i);
            end
        end
    end

    always_comb begin
        gnt      = '0;
        op_sel   = '0;
        op_valid = 1'b0;
        if (mul_en) begin
            if (found_hi) begin
                gnt      = gnt_hi;
                op_sel   = sel_hi;
                op_valid = 1'b1;
            end else if (found_lo) begin
                gnt      = gnt_lo;
                op_sel   = sel_lo;
                op_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            ptr_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            // Tags simply follow the enable; their value only matters under vld.
            if (mul_en) begin
                tag_q[0] <= op_sel;
                for (int k = 1; k < LAT; k++) begin
                    tag_q[k] <= tag_q[k-1];
                end
            end
            // Flush wins over both shifting and stalling.
            if (flush) begin
                vld_q <= '0;
            end else if (mul_en) begin
                vld_q[0] <= op_valid;
                for (int k = 1; k < LAT; k++) begin
                    vld_q[k] <= vld_q[k-1];
                end
            end
            // A grant shown during flush is discarded, so it does not consume a turn.
            if (op_valid && !flush) begin
                if (op_sel == TAG_W'(NREQ - 1)) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= op_sel + TAG_W'(1);
                end
            end
        end
    end

`ifdef FP_MUL_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue <= '0;
            perf_stall <= '0;
            perf_done  <= '0;
        end else begin
            if (op_valid && (perf_issue != 32'hFFFF_FFFF)) begin
                perf_issue <= perf_issue + 32'd1;
            end
            if (!mul_en && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (out_valid && out_ready && (perf_done != 32'hFFFF_FFFF)) begin
                perf_done <= perf_done + 32'd1;
            end
        end
    end
`endif

endmodule
